// File: rtl/sumador_4_pkg.sv
// Shared processor constants for the fetch path, plus a small address helper.
package sumador_4_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// 4-bit carry-lookahead adder slice with group generate/propagate terms.
module cla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gen,
  output logic       prop,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is flattened so no carry ripples inside the slice
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign prop = &p;
  assign cout = gen | (prop & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/sumador_4.sv
// PC + INC incrementer for the fetch path: combinational result and flags,
// plus a registered copy of each for the PC bank and trace.
module sumador_4
  import sumador_4_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int INC   = INSTR_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inputPC,
  output logic [WIDTH-1:0] Nextinst,
  output logic             wrap,
  output logic             misaligned,
  output logic [WIDTH-1:0] Nextinst_r,
  output logic             wrap_r,
  output logic             misaligned_r
);

  localparam int         NSLICE = WIDTH / 4;
  localparam logic [3:0] INC4   = 4'(INC);

  logic [NSLICE:0]   carry;
  logic [WIDTH-1:0]  sum;
  // Group terms are not consumed here; they exist for a future lookahead unit
  logic [NSLICE-1:0] group_g_unused;
  logic [NSLICE-1:0] group_p_unused;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    localparam logic [3:0] BOP = (i == 0) ? INC4 : 4'd0;

    cla_slice4 u_slice (
      .a    (inputPC[4*i +: 4]),
      .b    (BOP),
      .cin  (carry[i]),
      .sum  (sum[4*i +: 4]),
      .gen  (group_g_unused[i]),
      .prop (group_p_unused[i]),
      .cout (carry[i+1])
    );
  end

  assign Nextinst   = sum;
  assign wrap       = carry[NSLICE];
  assign misaligned = addr_misaligned(inputPC[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      Nextinst_r   <= '0;
      wrap_r       <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      Nextinst_r   <= Nextinst;
      wrap_r       <= wrap;
      misaligned_r <= misaligned;
    end
  end

endmodule

// File: tb/tb_sumador_4.sv
// Directed and random checks of sumador_4 against hand-computed values
// and a 65-bit reference sum.
module tb_sumador_4;

  logic        clk;
  logic        reset;
  logic [63:0] inputPC;
  logic [63:0] Nextinst;
  logic        wrap;
  logic        misaligned;
  logic [63:0] Nextinst_r;
  logic        wrap_r;
  logic        misaligned_r;

  int assertCount;
  int failCount;

  sumador_4 dut (
    .clk          (clk),
    .reset        (reset),
    .inputPC      (inputPC),
    .Nextinst     (Nextinst),
    .wrap         (wrap),
    .misaligned   (misaligned),
    .Nextinst_r   (Nextinst_r),
    .wrap_r       (wrap_r),
    .misaligned_r (misaligned_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before checks
  task automatic applyStimulus(input logic [63:0] pc, input logic rst);
    @(negedge clk);
    inputPC = pc;
    reset   = rst;
    #1;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [64:0] refSum;
    logic [63:0] pc;
    logic [63:0] expNext;
    logic        expWrap;
    logic        expMis;

    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    inputPC     = 64'h0;

    nextEdge();
    checkOutput("rst_next",     Nextinst,          64'h4);
    checkOutput("rst_wrap",     64'(wrap),         64'h0);
    checkOutput("rst_mis",      64'(misaligned),   64'h0);
    checkOutput("rst_next_r",   Nextinst_r,        64'h0);
    checkOutput("rst_wrap_r",   64'(wrap_r),       64'h0);
    checkOutput("rst_mis_r",    64'(misaligned_r), 64'h0);

    applyStimulus(64'h0, 1'b0);
    nextEdge();
    checkOutput("post_rst_next_r", Nextinst_r, 64'h4);

    applyStimulus(64'h0000_0000_0000_FFFC, 1'b0);
    checkOutput("slice_carry_next", Nextinst,   64'h0000_0000_0001_0000);
    checkOutput("slice_carry_wrap", 64'(wrap),  64'h0);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    checkOutput("top_next", Nextinst,  64'h0);
    checkOutput("top_wrap", 64'(wrap), 64'h1);
    nextEdge();
    checkOutput("top_wrap_r", 64'(wrap_r), 64'h1);
    checkOutput("top_next_r", Nextinst_r,  64'h0);

    applyStimulus(64'h1002, 1'b0);
    checkOutput("mis_flag", 64'(misaligned), 64'h1);
    checkOutput("mis_next", Nextinst,        64'h1006);
    nextEdge();
    checkOutput("mis_flag_r", 64'(misaligned_r), 64'h1);
    checkOutput("mis_next_r", Nextinst_r,        64'h1006);

    applyStimulus(64'h400, 1'b0);
    nextEdge();
    checkOutput("seq0_next_r", Nextinst_r, 64'h404);
    applyStimulus(64'h404, 1'b0);
    nextEdge();
    checkOutput("seq1_next_r", Nextinst_r, 64'h408);
    applyStimulus(64'h408, 1'b1);
    checkOutput("seq2_next_pre", Nextinst, 64'h40C);
    nextEdge();
    checkOutput("seq2_next_r_rst", Nextinst_r, 64'h0);
    checkOutput("seq2_next_rst",   Nextinst,   64'h40C);
    applyStimulus(64'h408, 1'b0);
    nextEdge();
    checkOutput("seq3_next_r", Nextinst_r, 64'h40C);

    for (int i = 0; i < 10000; i++) begin
      pc = {$urandom, $urandom};
      if (i % 16 == 0) pc[63:4] = '1;
      refSum  = {1'b0, pc} + 65'd4;
      expNext = refSum[63:0];
      expWrap = refSum[64];
      expMis  = (pc[1:0] != 2'b00);
      applyStimulus(pc, 1'b0);
      checkOutput("rnd_next", Nextinst,        expNext);
      checkOutput("rnd_wrap", 64'(wrap),       64'(expWrap));
      checkOutput("rnd_mis",  64'(misaligned), 64'(expMis));
      nextEdge();
      checkOutput("rnd_next_r", Nextinst_r,        expNext);
      checkOutput("rnd_wrap_r", 64'(wrap_r),       64'(expWrap));
      checkOutput("rnd_mis_r",  64'(misaligned_r), 64'(expMis));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sumador_4.md
# sumador_4

Program-counter incrementer for the unicycle processor fetch path. It takes the current 64-bit PC and produces the sequential next-instruction address, PC + 4. The combinational result feeds the next-PC multiplexer in the same cycle. A registered copy and status flags are also provided for the PC register bank and for debug/trace.

## Interface
Parameters:
- WIDTH, 64, address width in bits; must be a multiple of 4.
- INC, 4, increment constant; must be less than 2^4 so that it fits in the lowest slice.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inputPC  input  WIDTH  current program counter.
- Nextinst  output  WIDTH  inputPC + INC, combinational, modulo 2^WIDTH.
- wrap  output  1  carry out of the addition, combinational (1 when inputPC >= 2^WIDTH − INC).
- misaligned  output  1  inputPC[1:0] != 0, combinational.
- Nextinst_r  output  WIDTH  Nextinst registered one cycle.
- wrap_r  output  1  wrap registered one cycle.
- misaligned_r  output  1  misaligned registered one cycle.

## Operation
- Nextinst = (inputPC + INC) mod 2^WIDTH. No saturation; overflow wraps to low addresses.
- wrap is the true carry out of bit WIDTH−1.
- misaligned is informational only; the sum is still computed on the raw inputPC.
- The adder is built from WIDTH/4 chained 4-bit carry-lookahead slices:
  - Slice 0 adds INC with carry-in 0.
  - Every other slice adds 0 plus the incoming carry, so it is effectively an incrementer.
  - Each slice produces generate/propagate outputs and a carry out.
  - The carry ripples slice to slice.
  - wrap is the carry out of the last slice.
- No X propagation is permitted from reset values. With inputPC driven, all combinational outputs are fully defined.
- The block has no state besides the three output registers.

## Timing
- Nextinst, wrap and misaligned: zero-cycle latency, purely combinational from inputPC.
- Registered outputs: one-cycle latency. At rising edge n, Nextinst_r, wrap_r and misaligned_r capture the combinational values present before edge n.
- Reset:
  - While reset = 1 at a rising edge, Nextinst_r = 0, wrap_r = 0 and misaligned_r = 0.
  - Combinational outputs are unaffected by reset.
  - Reset asserted mid-stream clears the registers on that edge.
  - The first edge after reset deasserts captures the current sum.
- Changes to inputPC between edges affect only the combinational outputs. There is no handshake and no enable; the registers update every cycle.

## Structure
- Shared processor package holds:
  - the XLEN = 64 constant;
  - the INSTR_BYTES = 4 constant, used as the default for INC.
- One sub-module, cla_slice4:
  - inputs: 4-bit a, 4-bit b, carry in;
  - outputs: 4-bit sum, group generate, group propagate, carry out.
- sumador_4 instantiates WIDTH/4 copies of cla_slice4 in a generate loop, plus the three output registers.

## Test plan
- Reset, then inputPC = 0:
  - Nextinst = 4, wrap = 0, misaligned = 0.
  - Nextinst_r = 0 during reset; Nextinst_r = 4 one edge after reset deasserts.
- inputPC = 0x0000_0000_0000_FFFC: Nextinst = 0x0000_0000_0001_0000, wrap = 0. This carries across slice boundaries.
- inputPC = 0xFFFF_FFFF_FFFF_FFFC: Nextinst = 0, wrap = 1, and wrap_r = 1 on the next edge.
- inputPC = 0x1002:
  - misaligned = 1, Nextinst = 0x1006.
  - misaligned_r = 1 on the next edge.
- Sequence 0x400, 0x404, 0x408 over three cycles, with reset asserted at the third edge:
  - Nextinst_r is 0x404 then 0x408.
  - Nextinst_r is 0 after the reset edge.
  - The combinational Nextinst = 0x40C throughout the reset cycle.
- 10,000 random inputPC values: Nextinst and wrap match a 65-bit reference sum, and the registered outputs match the previous cycle's combinational values.
